// File: rtl/bp_me_pkg.sv
// Shared definitions for the memory-edge wormhole endpoint.
//
// Contents:
//   BP_ME_WORMHOLE_HEADER_S_DECLARE(name, flit_w, cord_w, len_w)
//       Macro that declares a packed wormhole header struct named 'name'.
//       Field order from LSB upward: dst_cord, len, src_cord, opaque.
//       Modules call it with their own parameters, so the struct always
//       matches their flit geometry.
//   bp_me_wormhole_header_s
//       Header struct for the default geometry: 64-bit flit, 8-bit cord,
//       4-bit len.
//   bp_me_rx_state_e
//       States of the command reassembly FSM.
//   bp_me_tx_state_e
//       States of the response serializer FSM.

`define BP_ME_WORMHOLE_HEADER_S_DECLARE(struct_name, flit_w, cord_w, len_w) \
    typedef struct packed { \
        logic [(flit_w)-2*(cord_w)-(len_w)-1:0] opaque; \
        logic [(cord_w)-1:0]                    src_cord; \
        logic [(len_w)-1:0]                     len; \
        logic [(cord_w)-1:0]                    dst_cord; \
    } struct_name

package bp_me_pkg;

    `BP_ME_WORMHOLE_HEADER_S_DECLARE(bp_me_wormhole_header_s, 64, 8, 4);

    typedef enum logic [1:0] {
        RX_HDR,
        RX_BODY,
        RX_DONE
    } bp_me_rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } bp_me_tx_state_e;

endpackage

// File: rtl/bp_me_wormhole_tx_serializer.sv
// Response serializer for the memory-edge endpoint.
// It captures one wide response packet from the memory and emits it on the
// mem_resp wormhole link. The packet goes out as the header flit followed by
// len body flits.
//
// Ports:
//   clk_i, reset_i          clock; synchronous active-high reset
//   mem_resp_i              wide response packet {body[max-1:0], header}
//   mem_resp_v_i            response valid
//   mem_resp_ready_and_o    response captured when v & ready
//   link_v_o                flit valid toward the mesh
//   link_data_o             current flit
//   link_ready_and_i        mesh accepts the flit
//   err_o                   sticky; set when a response header carries len > max

module bp_me_wormhole_tx_serializer
    import bp_me_pkg::*;
#(
    parameter int flit_width_p        = 64,
    parameter int cord_width_p        = 8,
    parameter int len_width_p         = 4,
    parameter int max_payload_flits_p = 8,
    localparam int pkt_width_lp       = flit_width_p*(1+max_payload_flits_p)
)(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [pkt_width_lp-1:0] mem_resp_i,
    input  logic                    mem_resp_v_i,
    output logic                    mem_resp_ready_and_o,
    output logic                    link_v_o,
    output logic [flit_width_p-1:0] link_data_o,
    input  logic                    link_ready_and_i,
    output logic                    err_o
);

    `BP_ME_WORMHOLE_HEADER_S_DECLARE(wh_header_s, flit_width_p, cord_width_p, len_width_p);

    localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_payload_flits_p);

    wh_header_s              resp_hdr;
    bp_me_tx_state_e         state_r, state_n;
    logic [pkt_width_lp-1:0] pkt_r;
    logic [len_width_p-1:0]  cnt_r;
    logic [len_width_p-1:0]  last_r;
    logic                    err_r;
    logic                    capture;
    logic                    flit_done;

    assign resp_hdr = mem_resp_i[flit_width_p-1:0];
    assign err_o    = err_r;

    // State register for the serializer FSM.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= TX_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic and handshakes.
    // Ready and valid are forced low while reset is asserted, so the
    // outputs are quiet in the reset cycle itself.
    always_comb begin
        state_n              = state_r;
        mem_resp_ready_and_o = 1'b0;
        link_v_o             = 1'b0;
        capture              = 1'b0;
        flit_done            = 1'b0;
        case (state_r)
            TX_IDLE: begin
                mem_resp_ready_and_o = ~reset_i;
                capture              = mem_resp_v_i & mem_resp_ready_and_o;
                if (capture) begin
                    state_n = TX_SEND;
                end
            end
            TX_SEND: begin
                link_v_o  = ~reset_i;
                flit_done = link_v_o & link_ready_and_i;
                if (flit_done && cnt_r == last_r) begin
                    state_n = TX_IDLE;
                end
            end
            default: state_n = TX_IDLE;
        endcase
    end

    // Packet register and flit counter.
    // last_r holds the clamped len, so an oversize header never indexes
    // past the payload that was captured.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            pkt_r  <= {mem_resp_i[pkt_width_lp-1:flit_width_p], resp_hdr};
            cnt_r  <= '0;
            last_r <= (resp_hdr.len > max_len_lp) ? max_len_lp : resp_hdr.len;
        end else if (flit_done && cnt_r != last_r) begin
            cnt_r <= cnt_r + len_width_p'(1);
        end
    end

    // Sticky error flag for oversize response lengths.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_r <= 1'b0;
        end else if (capture && resp_hdr.len > max_len_lp) begin
            err_r <= 1'b1;
        end
    end

    // Flit select from the packet register.
    // The output is held at zero whenever no flit is being offered.
    always_comb begin
        link_data_o = '0;
        if (link_v_o) begin
            for (int i = 0; i <= max_payload_flits_p; i++) begin
                if (cnt_r == len_width_p'(i)) begin
                    link_data_o = pkt_r[i*flit_width_p +: flit_width_p];
                end
            end
        end
    end

endmodule

// File: rtl/bp_me_wormhole_edge_responder.sv
// Memory-side endpoint at the south edge of the mem NoC mesh.
// Incoming mem_cmd wormhole flits are reassembled into one wide command
// packet for the memory. Wide memory responses are serialized back onto the
// mem_resp link. The two directions run independently.
//
// Ports:
//   clk_i, reset_i          clock; synchronous active-high reset
//   link_v_i / link_data_i / link_ready_and_o
//                           mem_cmd flit input from the mesh
//   link_v_o / link_data_o / link_ready_and_i
//                           mem_resp flit output to the mesh
//   mem_cmd_o / mem_cmd_v_o / mem_cmd_ready_and_i
//                           assembled command {body[max-1:0], header}
//   mem_resp_i / mem_resp_v_i / mem_resp_ready_and_o
//                           wide response from the memory
//   err_o                   sticky; set on an illegal len in either direction

module bp_me_wormhole_edge_responder
    import bp_me_pkg::*;
#(
    parameter int flit_width_p        = 64,
    parameter int cord_width_p        = 8,
    parameter int len_width_p         = 4,
    parameter int max_payload_flits_p = 8,
    localparam int pkt_width_lp       = flit_width_p*(1+max_payload_flits_p)
)(
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    link_v_i,
    input  logic [flit_width_p-1:0] link_data_i,
    output logic                    link_ready_and_o,

    output logic                    link_v_o,
    output logic [flit_width_p-1:0] link_data_o,
    input  logic                    link_ready_and_i,

    output logic [pkt_width_lp-1:0] mem_cmd_o,
    output logic                    mem_cmd_v_o,
    input  logic                    mem_cmd_ready_and_i,

    input  logic [pkt_width_lp-1:0] mem_resp_i,
    input  logic                    mem_resp_v_i,
    output logic                    mem_resp_ready_and_o,

    output logic                    err_o
);

    `BP_ME_WORMHOLE_HEADER_S_DECLARE(wh_header_s, flit_width_p, cord_width_p, len_width_p);

    localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_payload_flits_p);

    wh_header_s              rx_hdr;
    bp_me_rx_state_e         rx_state_r, rx_state_n;
    logic [flit_width_p-1:0] slot_r [0:max_payload_flits_p];
    logic [len_width_p-1:0]  rx_cnt_r;
    logic [len_width_p-1:0]  rx_len_r;
    logic [len_width_p:0]    rx_cnt_inc;
    logic                    rx_accept;
    logic                    rx_err_r;
    logic                    tx_err;

    assign rx_hdr     = link_data_i;
    assign rx_cnt_inc = {1'b0, rx_cnt_r} + (len_width_p+1)'(1);

    // State register for the reassembly FSM.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_state_r <= RX_HDR;
        end else begin
            rx_state_r <= rx_state_n;
        end
    end

    // Next-state logic and handshakes.
    // RX_DONE never accepts a flit, which costs one bubble cycle per
    // packet. The mem_cmd output therefore stays stable until the memory
    // consumes it. rx_len_r keeps the raw received len, so an oversize
    // packet is drained completely before the FSM returns to RX_HDR.
    always_comb begin
        rx_state_n       = rx_state_r;
        link_ready_and_o = 1'b0;
        mem_cmd_v_o      = 1'b0;
        rx_accept        = 1'b0;
        case (rx_state_r)
            RX_HDR: begin
                link_ready_and_o = ~reset_i;
                rx_accept        = link_v_i & link_ready_and_o;
                if (rx_accept) begin
                    rx_state_n = (rx_hdr.len == '0) ? RX_DONE : RX_BODY;
                end
            end
            RX_BODY: begin
                link_ready_and_o = ~reset_i;
                rx_accept        = link_v_i & link_ready_and_o;
                if (rx_accept && rx_cnt_inc == {1'b0, rx_len_r}) begin
                    rx_state_n = RX_DONE;
                end
            end
            RX_DONE: begin
                mem_cmd_v_o = ~reset_i;
                if (mem_cmd_ready_and_i) begin
                    rx_state_n = RX_HDR;
                end
            end
            default: rx_state_n = RX_HDR;
        endcase
    end

    // Packet buffer.
    // The header lands in slot 0 and the body slots are cleared, so a short
    // packet presents zeros in its unused flits. Body flit n goes to slot n.
    // Flits numbered above max_payload_flits_p match no slot and are dropped.
    always_ff @(posedge clk_i) begin
        if (rx_accept) begin
            if (rx_state_r == RX_HDR) begin
                slot_r[0] <= rx_hdr;
                for (int i = 1; i <= max_payload_flits_p; i++) begin
                    slot_r[i] <= '0;
                end
                rx_cnt_r <= '0;
                rx_len_r <= rx_hdr.len;
            end else begin
                for (int i = 1; i <= max_payload_flits_p; i++) begin
                    if (rx_cnt_inc == (len_width_p+1)'(i)) begin
                        slot_r[i] <= link_data_i;
                    end
                end
                rx_cnt_r <= rx_cnt_inc[len_width_p-1:0];
            end
        end
    end

    // Sticky error flag for oversize command lengths.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_err_r <= 1'b0;
        end else if (rx_accept && rx_state_r == RX_HDR && rx_hdr.len > max_len_lp) begin
            rx_err_r <= 1'b1;
        end
    end

    // Pack the slots into the wide command.
    // The command is held at zero whenever it is not valid.
    always_comb begin
        mem_cmd_o = '0;
        if (mem_cmd_v_o) begin
            for (int i = 0; i <= max_payload_flits_p; i++) begin
                mem_cmd_o[i*flit_width_p +: flit_width_p] = slot_r[i];
            end
        end
    end

    bp_me_wormhole_tx_serializer #(
        .flit_width_p        (flit_width_p),
        .cord_width_p        (cord_width_p),
        .len_width_p         (len_width_p),
        .max_payload_flits_p (max_payload_flits_p)
    ) tx_serializer (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .mem_resp_i           (mem_resp_i),
        .mem_resp_v_i         (mem_resp_v_i),
        .mem_resp_ready_and_o (mem_resp_ready_and_o),
        .link_v_o             (link_v_o),
        .link_data_o          (link_data_o),
        .link_ready_and_i     (link_ready_and_i),
        .err_o                (tx_err)
    );

    assign err_o = ~reset_i & (rx_err_r | tx_err);

endmodule

// File: tb/tb_bp_me_wormhole_edge_responder.sv
// Directed self-checking bench for bp_me_wormhole_edge_responder.
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// 1 time unit later, well away from the next edge.

module tb_bp_me_wormhole_edge_responder;

    localparam int FW = 64;
    localparam int CW = 8;
    localparam int LW = 4;
    localparam int MP = 8;
    localparam int PW = FW*(1+MP);

    logic          clk = 1'b0;
    logic          reset_i;
    logic          link_v_i;
    logic [FW-1:0] link_data_i;
    logic          link_ready_and_o;
    logic          link_v_o;
    logic [FW-1:0] link_data_o;
    logic          link_ready_and_i;
    logic [PW-1:0] mem_cmd_o;
    logic          mem_cmd_v_o;
    logic          mem_cmd_ready_and_i;
    logic [PW-1:0] mem_resp_i;
    logic          mem_resp_v_i;
    logic          mem_resp_ready_and_o;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bp_me_wormhole_edge_responder #(
        .flit_width_p        (FW),
        .cord_width_p        (CW),
        .len_width_p         (LW),
        .max_payload_flits_p (MP)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .link_v_i             (link_v_i),
        .link_data_i          (link_data_i),
        .link_ready_and_o     (link_ready_and_o),
        .link_v_o             (link_v_o),
        .link_data_o          (link_data_o),
        .link_ready_and_i     (link_ready_and_i),
        .mem_cmd_o            (mem_cmd_o),
        .mem_cmd_v_o          (mem_cmd_v_o),
        .mem_cmd_ready_and_i  (mem_cmd_ready_and_i),
        .mem_resp_i           (mem_resp_i),
        .mem_resp_v_i         (mem_resp_v_i),
        .mem_resp_ready_and_o (mem_resp_ready_and_o),
        .err_o                (err_o)
    );

    // Header flit: opaque | src_cord | len | dst_cord
    function automatic logic [FW-1:0] mkHdr(input logic [CW-1:0] dst, input logic [LW-1:0] len,
                                            input logic [CW-1:0] src);
        return {{(FW-2*CW-LW){1'b0}}, src, len, dst};
    endfunction

    function automatic logic [FW-1:0] slot(input int i);
        return mem_cmd_o[i*FW +: FW];
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [FW-1:0] d);
        link_v_i    = v;
        link_data_i = d;
    endtask

    task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [FW-1:0] h1, h2, h2b, h4, h6, h6b, ch, rh, rhdr;
        logic [PW-1:0] rpkt, rpkt2;
        logic [FW-1:0] rf [0:MP];
        int            idx;

        reset_i             = 1'b1;
        link_v_i            = 1'b0;
        link_data_i         = '0;
        link_ready_and_i    = 1'b0;
        mem_cmd_ready_and_i = 1'b0;
        mem_resp_v_i        = 1'b0;
        mem_resp_i          = '0;

        // reset state
        nextCycle();
        #1;
        checkBit("rst_link_rdy", link_ready_and_o, 1'b0);
        checkBit("rst_resp_rdy", mem_resp_ready_and_o, 1'b0);
        checkBit("rst_cmd_v", mem_cmd_v_o, 1'b0);
        checkBit("rst_link_v", link_v_o, 1'b0);
        checkBit("rst_err", err_o, 1'b0);
        nextCycle();
        reset_i = 1'b0;
        #1;
        checkBit("idle_link_rdy", link_ready_and_o, 1'b1);
        checkBit("idle_resp_rdy", mem_resp_ready_and_o, 1'b1);
        checkBit("idle_cmd_v", mem_cmd_v_o, 1'b0);

        // 1: header-only command
        h1 = mkHdr(8'h10, 4'd0, 8'h01);
        nextCycle();
        applyStimulus(1'b1, h1);
        #1;
        checkBit("t1_rdy", link_ready_and_o, 1'b1);
        nextCycle();
        applyStimulus(1'b0, '0);
        mem_cmd_ready_and_i = 1'b1;
        #1;
        checkBit("t1_v", mem_cmd_v_o, 1'b1);
        checkBit("t1_link_rdy", link_ready_and_o, 1'b0);
        checkOutput("t1_hdr", slot(0), h1);
        checkOutput("t1_body1", slot(1), 64'h0);
        checkOutput("t1_body8", slot(8), 64'h0);
        checkBit("t1_err", err_o, 1'b0);
        nextCycle();
        mem_cmd_ready_and_i = 1'b0;
        #1;
        checkBit("t1_v_clr", mem_cmd_v_o, 1'b0);
        checkBit("t1_rdy_back", link_ready_and_o, 1'b1);

        // 2: len=3 command with memory backpressure
        h2  = mkHdr(8'h21, 4'd3, 8'h02);
        h2b = mkHdr(8'h20, 4'd0, 8'h03);
        nextCycle();
        applyStimulus(1'b1, h2);
        nextCycle();
        applyStimulus(1'b1, 64'hA);
        nextCycle();
        applyStimulus(1'b1, 64'hB);
        nextCycle();
        applyStimulus(1'b1, 64'hC);
        #1;
        checkBit("t2_rdy_c", link_ready_and_o, 1'b1);
        checkBit("t2_not_done", mem_cmd_v_o, 1'b0);
        nextCycle();
        applyStimulus(1'b1, h2b);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkBit("t2_hold_v", mem_cmd_v_o, 1'b1);
            checkBit("t2_hold_rdy", link_ready_and_o, 1'b0);
            checkOutput("t2_hold_hdr", slot(0), h2);
            checkOutput("t2_hold_c", slot(3), 64'hC);
            nextCycle();
        end
        mem_cmd_ready_and_i = 1'b1;
        #1;
        checkBit("t2_v_last", mem_cmd_v_o, 1'b1);
        checkOutput("t2_slot1", slot(1), 64'hA);
        checkOutput("t2_slot2", slot(2), 64'hB);
        checkOutput("t2_slot4", slot(4), 64'h0);
        checkBit("t2_rdy_last", link_ready_and_o, 1'b0);
        nextCycle();
        mem_cmd_ready_and_i = 1'b0;
        #1;
        checkBit("t2_rdy_after", link_ready_and_o, 1'b1);
        checkBit("t2_v_after", mem_cmd_v_o, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0);
        #1;
        checkBit("t2b_v", mem_cmd_v_o, 1'b1);
        checkOutput("t2b_hdr", slot(0), h2b);
        checkOutput("t2b_cleared", slot(1), 64'h0);
        mem_cmd_ready_and_i = 1'b1;
        nextCycle();
        mem_cmd_ready_and_i = 1'b0;

        // 3: max-length response with toggling link ready
        rhdr = mkHdr(8'h05, 4'd8, 8'h00);
        rf[0] = rhdr;
        for (int i = 1; i <= MP; i++) rf[i] = 64'h1000 + 64'(i);
        for (int i = 0; i <= MP; i++) rpkt[i*FW +: FW] = rf[i];
        nextCycle();
        mem_resp_v_i = 1'b1;
        mem_resp_i   = rpkt;
        #1;
        checkBit("t3_resp_rdy", mem_resp_ready_and_o, 1'b1);
        checkBit("t3_link_v0", link_v_o, 1'b0);
        nextCycle();
        mem_resp_v_i = 1'b0;
        mem_resp_i   = '0;
        idx = 0;
        for (int c = 0; c < 40 && idx < 9; c++) begin
            link_ready_and_i = (c % 2 == 0);
            #1;
            checkBit("t3_v", link_v_o, 1'b1);
            checkOutput("t3_flit", link_data_o, rf[idx]);
            checkBit("t3_busy", mem_resp_ready_and_o, 1'b0);
            if (link_ready_and_i) idx++;
            nextCycle();
        end
        link_ready_and_i = 1'b0;
        #1;
        checkOutput("t3_count", 64'(idx), 64'd9);
        checkBit("t3_done_v", link_v_o, 1'b0);
        checkBit("t3_done_rdy", mem_resp_ready_and_o, 1'b1);
        checkBit("t3_err", err_o, 1'b0);

        // 5: concurrent len=2 command and len=2 response
        ch = mkHdr(8'h31, 4'd2, 8'h04);
        rh = mkHdr(8'h06, 4'd2, 8'h00);
        rpkt2 = '0;
        rpkt2[0*FW +: FW] = rh;
        rpkt2[1*FW +: FW] = 64'h2001;
        rpkt2[2*FW +: FW] = 64'h2002;
        nextCycle();
        applyStimulus(1'b1, ch);
        mem_resp_v_i = 1'b1;
        mem_resp_i   = rpkt2;
        #1;
        checkBit("t5_rx_rdy0", link_ready_and_o, 1'b1);
        checkBit("t5_resp_rdy0", mem_resp_ready_and_o, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 64'h3001);
        mem_resp_v_i     = 1'b0;
        mem_resp_i       = '0;
        link_ready_and_i = 1'b1;
        #1;
        checkBit("t5_tx_v0", link_v_o, 1'b1);
        checkOutput("t5_tx_f0", link_data_o, rh);
        checkBit("t5_rx_rdy1", link_ready_and_o, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 64'h3002);
        #1;
        checkOutput("t5_tx_f1", link_data_o, 64'h2001);
        nextCycle();
        applyStimulus(1'b0, '0);
        mem_cmd_ready_and_i = 1'b1;
        #1;
        checkOutput("t5_tx_f2", link_data_o, 64'h2002);
        checkBit("t5_rx_v", mem_cmd_v_o, 1'b1);
        checkOutput("t5_slot0", slot(0), ch);
        checkOutput("t5_slot1", slot(1), 64'h3001);
        checkOutput("t5_slot2", slot(2), 64'h3002);
        checkOutput("t5_slot3", slot(3), 64'h0);
        nextCycle();
        link_ready_and_i    = 1'b0;
        mem_cmd_ready_and_i = 1'b0;
        #1;
        checkBit("t5_tx_idle", link_v_o, 1'b0);
        checkBit("t5_resp_rdy", mem_resp_ready_and_o, 1'b1);
        checkBit("t5_rx_v_clr", mem_cmd_v_o, 1'b0);
        checkBit("t5_rx_rdy", link_ready_and_o, 1'b1);
        checkBit("t5_err", err_o, 1'b0);

        // 4: oversize command len=12 with max 8
        h4 = mkHdr(8'h33, 4'd12, 8'h02);
        nextCycle();
        applyStimulus(1'b1, h4);
        nextCycle();
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 64'hD00 + 64'(i));
            #1;
            checkBit("t4_rdy", link_ready_and_o, 1'b1);
            checkBit("t4_drain_v", mem_cmd_v_o, 1'b0);
            checkBit("t4_err_early", err_o, 1'b1);
            nextCycle();
        end
        applyStimulus(1'b0, '0);
        #1;
        checkBit("t4_v", mem_cmd_v_o, 1'b1);
        checkBit("t4_link_rdy", link_ready_and_o, 1'b0);
        checkOutput("t4_slot1", slot(1), 64'hD01);
        checkOutput("t4_slot5", slot(5), 64'hD05);
        checkOutput("t4_slot8", slot(8), 64'hD08);
        mem_cmd_ready_and_i = 1'b1;
        nextCycle();
        mem_cmd_ready_and_i = 1'b0;
        #1;
        checkBit("t4_err_sticky", err_o, 1'b1);
        checkBit("t4_back_idle", link_ready_and_o, 1'b1);

        // 6: reset in the middle of a packet
        h6  = mkHdr(8'h44, 4'd3, 8'h05);
        h6b = mkHdr(8'h55, 4'd1, 8'h06);
        nextCycle();
        applyStimulus(1'b1, h6);
        nextCycle();
        applyStimulus(1'b1, 64'hE0);
        nextCycle();
        applyStimulus(1'b0, '0);
        reset_i = 1'b1;
        #1;
        checkBit("t6_rst_link_rdy", link_ready_and_o, 1'b0);
        checkBit("t6_rst_resp_rdy", mem_resp_ready_and_o, 1'b0);
        checkBit("t6_rst_cmd_v", mem_cmd_v_o, 1'b0);
        checkBit("t6_rst_link_v", link_v_o, 1'b0);
        checkBit("t6_rst_err", err_o, 1'b0);
        nextCycle();
        reset_i = 1'b0;
        #1;
        checkBit("t6_rdy", link_ready_and_o, 1'b1);
        checkBit("t6_err_clr", err_o, 1'b0);
        applyStimulus(1'b1, h6b);
        nextCycle();
        applyStimulus(1'b1, 64'hE1);
        nextCycle();
        applyStimulus(1'b0, '0);
        #1;
        checkBit("t6_v", mem_cmd_v_o, 1'b1);
        checkOutput("t6_hdr", slot(0), h6b);
        checkOutput("t6_slot1", slot(1), 64'hE1);
        checkOutput("t6_slot2", slot(2), 64'h0);
        mem_cmd_ready_and_i = 1'b1;
        nextCycle();
        mem_cmd_ready_and_i = 1'b0;
        #1;
        checkBit("t6_done", mem_cmd_v_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
